// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit.
// Stage indices, default widths and flush FSM encoding.
package pipe_ctrl_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_AW    = 32;
  localparam int DEF_CNT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Holds at MAX instead of wrapping; clr beats inc.
module sat_cnt #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // count up to MAX, clear wins
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && cnt != MAX)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, exception flush
// sequencer, stall-cycle counter and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES       = 5,
  parameter int AW           = DEF_AW,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              exc_req,
  input  logic [AW-1:0]     exc_pc,
  input  logic              cnt_clr,
  output logic [STAGES:0]   stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  localparam int FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  fsm_e          state;
  fsm_e          state_nxt;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic [STAGES-1:0] above;
  logic [TW-1:0] run;

  // thermometer stall: everything up to the
  // highest requester plus the PC holds
  always_comb begin
    above = '0;
    above[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--)
      above[i] = stall_req[i] | above[i+1];
    stall = '0;
    if (!rst && state == IDLE)
      stall = {above, above[0]};
  end

  // flush FSM next state
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      IDLE: begin
        if (exc_req) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt == '0)
          state_nxt = IDLE;
        else
          fcnt_nxt = fcnt - FW'(1);
      end
    endcase
  end

  // flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  assign flush = (state == FLUSH);

  // capture the redirect target on acceptance
  always_ff @(posedge clk) begin
    if (rst)
      new_pc <= '0;
    else if (state == IDLE && exc_req)
      new_pc <= exc_pc;
  end

  sat_cnt #(
    .W   (CNT_W)
  ) u_cyc (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .clr (cnt_clr),
    .cnt (stall_cycles)
  );

  sat_cnt #(
    .W   (TW),
    .MAX (TW'(TIMEOUT))
  ) u_run (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .clr (!stall[0]),
    .cnt (run)
  );

  // sticky watchdog, disabled when TIMEOUT is 0
  always_ff @(posedge clk) begin
    if (rst)
      stall_timeout <= 1'b0;
    else if (TIMEOUT != 0 && run == TW'(TIMEOUT))
      stall_timeout <= 1'b1;
  end

endmodule
